trojan_seq: RTL and testbench
=============================

TROJAN_SEQ -- requirements
Module: trojan_seq

Interface
REQ-001 SHALL have parameter KEY_W, default 56, key and payload width in bits.
REQ-002 SHALL have parameter TRIG_W, default 32, trigger bus width.
REQ-003 SHALL have parameter MATCH_W, default 4, number of trigger LSBs compared (1..TRIG_W).
REQ-004 SHALL have parameter PATTERN, default 0, MATCH_W-bit match value.
REQ-005 SHALL have parameter COUNT_N, default 3, consecutive valid matches needed to fire (1..255).
REQ-006 SHALL have parameter PAYLOAD_MASK, default 1, KEY_W-bit XOR mask applied to key when active.
REQ-007 SHALL have parameter HOLD_CYCLES, default 8, payload active duration in cycles; 0 = persistent until reset.
REQ-008 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port key  input  KEY_W  clean key.
REQ-011 SHALL have port trigger  input  TRIG_W  trigger observation bus.
REQ-012 SHALL have port trig_valid  input  1  trigger sample qualifier.
REQ-013 SHALL have port payload  output  KEY_W  key, or key XOR PAYLOAD_MASK while active.
REQ-014 SHALL have port active  output  1  high while in FIRE.
REQ-015 SHALL have port match_cnt  output  8  current consecutive-match count.

Function
REQ-016 SHALL define a match as trig_valid=1 and trigger[MATCH_W-1:0]==PATTERN.
REQ-017 SHALL define a miss as trig_valid=1 and trigger[MATCH_W-1:0]!=PATTERN; trig_valid=0 cycles are neither and SHALL hold all state.
REQ-018 SHALL implement states IDLE, COUNT, FIRE, encoded in a registered state variable.
REQ-019 IDLE: match with COUNT_N=1 -> FIRE; match with COUNT_N>1 -> COUNT, match_cnt=1; miss -> stay, match_cnt=0.
REQ-020 COUNT: match -> match_cnt+1; when match_cnt+1==COUNT_N -> FIRE; miss -> IDLE, match_cnt=0.
REQ-021 On entry to FIRE, match_cnt SHALL be set to 0 and hold counter loaded with HOLD_CYCLES.
REQ-022 FIRE: hold counter SHALL decrement every clk cycle regardless of trig_valid; at count 1 next state IDLE, so active is high exactly HOLD_CYCLES cycles.
REQ-023 FIRE with HOLD_CYCLES=0: SHALL remain in FIRE until rst_n asserted.
REQ-024 Matches and misses during FIRE SHALL be ignored; counting restarts only after return to IDLE.
REQ-025 active SHALL be high in the cycle after the COUNT_N-th match edge (one-cycle latency from sampling to effect).
REQ-026 payload SHALL be combinational from key and the registered active: key XOR PAYLOAD_MASK when active=1, else key, with zero key-to-payload latency.
REQ-027 match_cnt SHALL never exceed COUNT_N-1 and SHALL not wrap.
REQ-028 Hold counter width SHALL be clog2(HOLD_CYCLES+1), minimum 1 bit.

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, force state IDLE, match_cnt=0, hold counter=0, active=0, payload=key.
REQ-030 Reset asserted mid-COUNT or mid-FIRE SHALL discard progress; after release, COUNT_N fresh matches are required.
REQ-031 Release of rst_n SHALL take effect on the first rising clk edge after deassertion; no match is sampled while rst_n=0.

Verification
REQ-032 Defaults, key=56'hA5A5_A5A5_A5A5_A4, trigger=0 valid 3 cycles -> active rises after 3rd edge, payload=56'hA5A5_A5A5_A5A5_A5 for 8 cycles, then returns to key.
REQ-033 Defaults, trigger sequence 0,0,5,0,0,0 all valid -> match_cnt 1,2,0,1,2, active only after the final 0.
REQ-034 Defaults, matches interleaved with trig_valid=0 cycles (0,-,0,-,0) -> fires after 3rd valid match; invalid cycles do not reset count.
REQ-035 HOLD_CYCLES=0, 3 matches then random trigger for 100 cycles -> active stays 1 until rst_n pulse, then 0 immediately (asynchronous).
REQ-036 Defaults, rst_n pulsed low mid-FIRE (cycle 4 of 8) -> active=0 during reset; after release two matches do not fire, third does.
REQ-037 COUNT_N=1, MATCH_W=8, PATTERN=8'h3C, PAYLOAD_MASK=56'hFF -> single valid 0x3C fires next cycle, payload low byte inverted; 0x13C on trigger also matches.

Source files
------------

// File: rtl/trojan_seq.sv
// rtl/trojan_seq.sv - sequential trigger: COUNT_N consecutive valid pattern matches
// flip the key through PAYLOAD_MASK for HOLD_CYCLES cycles (0 = until reset).
module trojan_seq #(
  parameter int                 KEY_W        = 56,
  parameter int                 TRIG_W       = 32,
  parameter int                 MATCH_W      = 4,
  parameter logic [MATCH_W-1:0] PATTERN      = '0,
  parameter int                 COUNT_N      = 3,
  parameter logic [KEY_W-1:0]   PAYLOAD_MASK = KEY_W'(1),
  parameter int                 HOLD_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trig_valid,
  output logic [KEY_W-1:0]  payload,
  output logic              active,
  output logic [7:0]        match_cnt
);

  localparam int                HOLD_W    = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  // match_cnt value at which one more match completes the sequence
  localparam logic [7:0]        CNT_LAST  = 8'(COUNT_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hit;
  logic              miss;

  assign hit  = trig_valid && (trigger[MATCH_W-1:0] == PATTERN);
  assign miss = trig_valid && (trigger[MATCH_W-1:0] != PATTERN);

  generate
    if (MATCH_W < TRIG_W) begin : g_hi
      logic unused_trig_hi;
      assign unused_trig_hi = ^trigger[TRIG_W-1:MATCH_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_cnt <= 8'd0;
      hold_cnt  <= '0;
      active    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (COUNT_N == 1) begin
              state     <= FIRE;
              active    <= 1'b1;
              hold_cnt  <= HOLD_LOAD;
              match_cnt <= 8'd0;
            end else begin
              state     <= COUNT;
              match_cnt <= 8'd1;
            end
          end else if (miss) begin
            match_cnt <= 8'd0;
          end
        end
        COUNT: begin
          if (hit) begin
            if (match_cnt == CNT_LAST) begin
              state     <= FIRE;
              active    <= 1'b1;
              hold_cnt  <= HOLD_LOAD;
              match_cnt <= 8'd0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end else if (miss) begin
            state     <= IDLE;
            match_cnt <= 8'd0;
          end
        end
        FIRE: begin
          // trigger activity is ignored here; only the hold timer matters
          if (HOLD_CYCLES != 0) begin
            if (hold_cnt == HOLD_W'(1)) begin
              state    <= IDLE;
              active   <= 1'b0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          match_cnt <= 8'd0;
          hold_cnt  <= '0;
          active    <= 1'b0;
        end
      endcase
    end
  end

  assign payload = active ? (key ^ PAYLOAD_MASK) : key;

endmodule

// File: tb/tb_trojan_seq.sv
// tb/tb_trojan_seq.sv - four parameterisations of trojan_seq on shared stimulus,
// checked against a streak/timer model.
module tb_trojan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] key = '0;
  logic [31:0] trigger = '0;
  logic        trig_valid = 1'b0;

  logic [55:0] pay [4];
  logic        act [4];
  logic [7:0]  mc  [4];

  always #5 clk = ~clk;

  // 0: defaults, 1: persistent, 2: single 8-bit match, 3: COUNT_N=2 HOLD=1
  trojan_seq u_def (.clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger), .trig_valid(trig_valid),
                    .payload(pay[0]), .active(act[0]), .match_cnt(mc[0]));
  trojan_seq #(.HOLD_CYCLES(0)) u_hold0 (.clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger),
                    .trig_valid(trig_valid), .payload(pay[1]), .active(act[1]), .match_cnt(mc[1]));
  trojan_seq #(.COUNT_N(1), .MATCH_W(8), .PATTERN(8'h3C), .PAYLOAD_MASK(56'hFF)) u_c1 (
                    .clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger), .trig_valid(trig_valid),
                    .payload(pay[2]), .active(act[2]), .match_cnt(mc[2]));
  trojan_seq #(.COUNT_N(2), .HOLD_CYCLES(1)) u_h1 (.clk(clk), .rst_n(rst_n), .key(key), .trigger(trigger),
                    .trig_valid(trig_valid), .payload(pay[3]), .active(act[3]), .match_cnt(mc[3]));

  int          cfg_cnt  [4] = '{3, 3, 1, 2};
  int          cfg_mw   [4] = '{4, 4, 8, 4};
  int          cfg_pat  [4] = '{0, 0, 'h3C, 0};
  int          cfg_hold [4] = '{8, 0, 8, 1};
  logic [55:0] cfg_mask [4] = '{56'd1, 56'd1, 56'hFF, 56'd1};

  int m_cnt  [4];
  bit m_fire [4];
  int m_left [4];

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_fire[i] = 0; m_left[i] = 0;
    end
  endfunction

  function automatic void model_step(logic v, logic [31:0] t);
    int low;
    for (int i = 0; i < 4; i++) begin
      low = int'(t & ((32'd1 << cfg_mw[i]) - 32'd1));
      if (m_fire[i]) begin
        if (cfg_hold[i] != 0) begin
          m_left[i]--;
          if (m_left[i] == 0) m_fire[i] = 0;
        end
      end else if (v) begin
        if (low == cfg_pat[i]) begin
          if (m_cnt[i] + 1 == cfg_cnt[i]) begin
            m_fire[i] = 1; m_cnt[i] = 0; m_left[i] = cfg_hold[i];
          end else begin
            m_cnt[i]++;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [55:0] exp_pay;
    for (int i = 0; i < 4; i++) begin
      exp_pay = m_fire[i] ? (key ^ cfg_mask[i]) : key;
      n_checks += 3;
      if (act[i] !== m_fire[i]) begin
        n_errors++;
        $display("FAIL %s dut%0d active: got %b expected %b at %0t", tag, i, act[i], m_fire[i], $time);
      end
      if (mc[i] !== 8'(m_cnt[i])) begin
        n_errors++;
        $display("FAIL %s dut%0d match_cnt: got %0d expected %0d at %0t", tag, i, mc[i], m_cnt[i], $time);
      end
      if (pay[i] !== exp_pay) begin
        n_errors++;
        $display("FAIL %s dut%0d payload: got %h expected %h at %0t", tag, i, pay[i], exp_pay, $time);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step(trig_valid, trigger);
    @(negedge clk);
    check_all(tag);
  endtask

  // called just after a negedge; asserts reset mid-cycle and releases at a later negedge
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    key = {$urandom, $urandom};
    trigger = '0; trig_valid = 1'b1;
    #1 model_reset();
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    trig_valid = 1'b0;
  endtask

  task automatic test_fire_basic();
    apply_reset("basic_rst");
    key = 56'hA5A5_A5A5_A5A5_A4;
    trigger = '0; trig_valid = 1'b1;
    repeat (3) tick("basic_match");
    trig_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_checks += 2;
      if (act[0] !== 1'b1) begin
        n_errors++; $display("FAIL basic_active cycle %0d: got %b expected 1", c, act[0]);
      end
      if (pay[0] !== 56'hA5A5_A5A5_A5A5_A5) begin
        n_errors++; $display("FAIL basic_payload cycle %0d: got %h expected a5a5a5a5a5a5a5", c, pay[0]);
      end
      tick("basic_hold");
    end
    n_checks++;
    if (act[0] !== 1'b0 || pay[0] !== key) begin
      n_errors++; $display("FAIL basic_release: active %b payload %h expected 0 / %h", act[0], pay[0], key);
    end
  endtask

  task automatic test_miss_restart();
    logic [31:0] seq [6] = '{0, 0, 5, 0, 0, 0};
    int          exp_mc  [6] = '{1, 2, 0, 1, 2, 0};
    bit          exp_act [6] = '{0, 0, 0, 0, 0, 1};
    apply_reset("miss_rst");
    trig_valid = 1'b1;
    for (int s = 0; s < 6; s++) begin
      trigger = seq[s];
      tick("miss_seq");
      n_checks += 2;
      if (mc[0] !== 8'(exp_mc[s])) begin
        n_errors++; $display("FAIL miss_cnt step %0d: got %0d expected %0d", s, mc[0], exp_mc[s]);
      end
      if (act[0] !== exp_act[s]) begin
        n_errors++; $display("FAIL miss_active step %0d: got %b expected %b", s, act[0], exp_act[s]);
      end
    end
    trig_valid = 1'b0;
    repeat (9) tick("miss_drain");
  endtask

  task automatic test_invalid_gaps();
    apply_reset("gap_rst");
    trigger = '0;
    for (int s = 0; s < 5; s++) begin
      trig_valid = (s % 2 == 0);
      tick("gap_seq");
      n_checks++;
      if (act[0] !== (s == 4)) begin
        n_errors++; $display("FAIL gap_active step %0d: got %b expected %b", s, act[0], s == 4);
      end
    end
    trig_valid = 1'b0;
    repeat (9) tick("gap_drain");
  endtask

  task automatic test_persistent();
    apply_reset("pers_rst");
    trigger = '0; trig_valid = 1'b1;
    repeat (3) tick("pers_match");
    for (int c = 0; c < 100; c++) begin
      trigger = $urandom; trig_valid = $urandom_range(0, 1);
      tick("pers_rand");
      n_checks++;
      if (act[1] !== 1'b1) begin
        n_errors++; $display("FAIL pers_active cycle %0d: got %b expected 1", c, act[1]);
      end
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_checks++;
    if (act[1] !== 1'b0) begin
      n_errors++; $display("FAIL pers_async_clear: got %b expected 0", act[1]);
    end
    check_all("pers_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_fire();
    apply_reset("mid_rst");
    trigger = '0; trig_valid = 1'b1;
    repeat (3) tick("mid_match");
    trig_valid = 1'b0;
    repeat (3) tick("mid_hold");
    apply_reset("mid_fire_rst");
    n_checks++;
    if (act[0] !== 1'b0) begin
      n_errors++; $display("FAIL mid_active_in_reset: got %b expected 0", act[0]);
    end
    trig_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick("mid_rematch");
      n_checks++;
      if (act[0] !== (s == 2)) begin
        n_errors++; $display("FAIL mid_refire step %0d: got %b expected %b", s, act[0], s == 2);
      end
    end
    trig_valid = 1'b0;
    repeat (9) tick("mid_drain");
  endtask

  task automatic test_single_match();
    apply_reset("single_rst");
    key = {$urandom, $urandom};
    trigger = 32'h13C; trig_valid = 1'b1;
    tick("single_fire");
    n_checks += 2;
    if (act[2] !== 1'b1) begin
      n_errors++; $display("FAIL single_active: got %b expected 1", act[2]);
    end
    if (pay[2] !== (key ^ 56'hFF)) begin
      n_errors++; $display("FAIL single_payload: got %h expected %h", pay[2], key ^ 56'hFF);
    end
    trig_valid = 1'b0;
    repeat (9) tick("single_drain");
  endtask

  task automatic test_random();
    apply_reset("rand_rst");
    for (int c = 0; c < 2000; c++) begin
      trigger = $urandom;
      case ($urandom_range(0, 3))
        0: trigger[7:0] = 8'h00;
        1: trigger[7:0] = 8'h3C;
        2: trigger[7:0] = 8'h30;
        default: ;
      endcase
      trig_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) key = {$urandom, $urandom};
      tick("random");
      if (c % 500 == 499) apply_reset("rand_mid_rst");
    end
  endtask

  initial begin
    test_reset();
    test_fire_basic();
    test_miss_restart();
    test_invalid_gaps();
    test_persistent();
    test_reset_mid_fire();
    test_single_match();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
